// File: rtl/updown_count_sched_pkg.sv
// Shared types and constants for the up/down count scheduler.
package updown_count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_count_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention
// the requester named by prio wins. Purely combinational, one-hot grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] grant
);

    // grant the single requester, or the prioritised one when both ask
    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | ~prio);
        grant[1] = req[1] & (~req[0] |  prio);
    end

endmodule

// File: rtl/updown_count_sched.sv
// Two-requester scheduler owning one shared wrapping up/down counter.
// A job (direction, step count) is accepted in IDLE, the counter steps once
// per cycle in RUN, and DONE emits a one-cycle completion pulse.
//
//  state | meaning
//  IDLE  | waiting for a job; ready offered to the arbiter winner
//  RUN   | stepping q once per cycle, remaining counts down to 1
//  DONE  | one-cycle done pulse, round-robin priority handed over
module updown_count_sched
    import updown_count_sched_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req0_dir,
    input  logic [LEN_W-1:0] req0_len,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_dir,
    input  logic [LEN_W-1:0] req1_len,
    output logic             req1_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             owner,
    output logic             done,
    output logic             done_id
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       grant;
    logic             prio;
    logic             dir_r;
    logic [LEN_W-1:0] remaining;
    logic             hs;
    logic             hs_dir;
    logic [LEN_W-1:0] hs_len;

    rr_arb2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .prio  (prio),
        .grant (grant)
    );

    // handshake decode; the grant is one-hot so at most one ready is high
    always_comb begin
        req0_ready = (state == IDLE) && grant[0];
        req1_ready = (state == IDLE) && grant[1];
        hs         = req0_ready || req1_ready;
        hs_dir     = grant[1] ? req1_dir : req0_dir;
        hs_len     = grant[1] ? req1_len : req0_len;
    end

    // next-state logic and state-decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        done_id   = (state == DONE) && owner;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nxt = (hs_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (remaining == LEN_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // job capture, step counter, shared q and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= '0;
            remaining <= '0;
            dir_r     <= DIR_UP;
            owner     <= 1'b0;
            prio      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        dir_r     <= hs_dir;
                        remaining <= hs_len;
                        owner     <= grant[1];
                    end
                end
                RUN: begin
                    q         <= (dir_r == DIR_DOWN) ? q - WIDTH'(1) : q + WIDTH'(1);
                    remaining <= remaining - LEN_W'(1);
                end
                DONE: begin
                    prio <= ~owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_updown_count_sched.sv
// Directed bench for updown_count_sched (WIDTH=3, LEN_W=4).
// Each table row is one clock cycle: inputs are driven after the falling
// edge and all outputs are checked 1 ns later, before the next rising edge.
module tb_updown_count_sched;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_dir, req0_ready;
    logic [3:0] req0_len;
    logic       req1_valid, req1_dir, req1_ready;
    logic [3:0] req1_len;
    logic [2:0] q;
    logic       busy, owner, done, done_id;

    int vectors;
    int miscompares;
    logic [2:0] q_model;

    updown_count_sched #(.WIDTH(3), .LEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_dir   (req0_dir),
        .req0_len   (req0_len),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_dir   (req1_dir),
        .req1_len   (req1_len),
        .req1_ready (req1_ready),
        .q          (q),
        .busy       (busy),
        .owner      (owner),
        .done       (done),
        .done_id    (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected vector layout: {r0, r1, q[2:0], busy, done, done_id, owner}
    typedef struct {
        logic       rst;
        logic       v0;
        logic       d0;
        logic [3:0] l0;
        logic       v1;
        logic       d1;
        logic [3:0] l1;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rs, input logic v0, input logic d0, input int l0,
                                input logic v1, input logic d1, input int l1,
                                input logic r0, input logic r1, input int eq,
                                input logic eb, input logic ed, input logic eid, input logic eo);
        vec_t v;
        v.rst = rs;
        v.v0  = v0;
        v.d0  = d0;
        v.l0  = 4'(l0);
        v.v1  = v1;
        v.d1  = d1;
        v.l1  = 4'(l1);
        v.exp = {r0, r1, 3'(eq), eb, ed, eid, eo};
        return v;
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // both ready outputs must never be high together
    always @(posedge clk) begin
        if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
            miscompares++;
            $display("FAIL both_ready at %0t: req0_ready=1 req1_ready=1 required at most one", $time);
        end
    end

    // one job submitted by requester n, followed step by step against q_model
    task automatic hand_job(input logic n, input logic dir, input logic [3:0] len);
        int cnt;
        logic rdy;
        @(negedge clk);
        if (n == 1'b0) begin
            req0_valid = 1'b1; req0_dir = dir; req0_len = len;
        end else begin
            req1_valid = 1'b1; req1_dir = dir; req1_len = len;
        end
        #1;
        cnt = 0;
        rdy = (n == 1'b0) ? req0_ready : req1_ready;
        while (rdy !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            #1;
            cnt++;
            rdy = (n == 1'b0) ? req0_ready : req1_ready;
        end
        vectors++;
        if (rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL hand_ready req%0d: no ready within 20 cycles, required ready=1", n);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (len == 4'd0)
            chk($sformatf("hand_zero req%0d", n), {3'b0, q, busy, done, done_id},
                {3'b0, q_model, 1'b1, 1'b1, n});
        else
            chk($sformatf("hand_start req%0d", n), {3'b0, q, busy, done, done_id},
                {3'b0, q_model, 1'b1, 1'b0, 1'b0});
        for (int k = 1; k <= int'(len); k++) begin
            @(posedge clk);
            #1;
            q_model = (dir == 1'b1) ? q_model - 3'd1 : q_model + 3'd1;
            if (k == int'(len))
                chk($sformatf("hand_last req%0d len%0d", n, len), {3'b0, q, busy, done, done_id},
                    {3'b0, q_model, 1'b1, 1'b1, n});
            else
                chk($sformatf("hand_step%0d req%0d", k, n), {3'b0, q, busy, done, done_id},
                    {3'b0, q_model, 1'b1, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        chk($sformatf("hand_idle req%0d", n), {3'b0, q, busy, done, done_id},
            {3'b0, q_model, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst        = 1'b1;
        req0_valid = 1'b0; req0_dir = 1'b0; req0_len = 4'd0;
        req1_valid = 1'b0; req1_dir = 1'b0; req1_len = 4'd0;

        //                rst v0 d0 l0 v1 d1 l1  r0 r1 q  busy done id own
        // req0 up 3 from reset
        vecs.push_back(mk(0, 1, 0, 3, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 1, 1, 0, 0));
        // reset, then req1 down 2 wraps 0 -> 7 -> 6
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 2,  0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 7, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 6, 1, 1, 1, 1));
        // reset, both contend: req0 first, then req1 wins the re-contention
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 6, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1,  0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1,  0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0,  0, 0, 2, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 2,  1, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2,  0, 0, 2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2,  0, 0, 3, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 2,  0, 1, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 3, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 4, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 1, 1, 1, 1));
        // zero-length job at q=5
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 5, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 0, 0, 0, 0));
        // up 6 aborted by reset after two steps; priority returns to req0
        vecs.push_back(mk(0, 1, 0, 6, 0, 0, 0,  1, 0, 5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 6, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 7, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1,  1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1,  0, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1,  0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            req0_valid = vecs[i].v0;
            req0_dir   = vecs[i].d0;
            req0_len   = vecs[i].l0;
            req1_valid = vecs[i].v1;
            req1_dir   = vecs[i].d1;
            req1_len   = vecs[i].l1;
            #1;
            chk($sformatf("vec%0d", i),
                {req0_ready, req1_ready, q, busy, done, done_id, owner}, vecs[i].exp);
        end

        @(negedge clk);
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // q is 0 after the table; bring it to 3, then a full 8-step wrap, then max length
        q_model = 3'd0;
        hand_job(1'b0, 1'b0, 4'd3);
        hand_job(1'b0, 1'b0, 4'd8);
        hand_job(1'b1, 1'b1, 4'd15);
        hand_job(1'b1, 1'b0, 4'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
